// File: rtl/user_reg_file.sv
// Parametrised user register file: NUM_RD read ports, one byte-strobed write port,
// write-first bypass, bulk fill sequencer, sticky out-of-range error and access counters.
module user_reg_file #(
    parameter int DATA_WIDTH    = 128,
    parameter int UR_ADDR_WIDTH = 11,
    parameter int DEPTH         = 64,
    parameter int NUM_RD        = 2,
    parameter int RD_LAT        = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ur_we,
    input  logic [UR_ADDR_WIDTH-1:0]          ur_waddr,
    input  logic [DATA_WIDTH-1:0]             ur_wdata,
    input  logic [DATA_WIDTH/8-1:0]           ur_wstrb,
    input  logic [NUM_RD-1:0]                 ur_re,
    input  logic [NUM_RD*UR_ADDR_WIDTH-1:0]   ur_raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]      ur_rdata,
    output logic [NUM_RD-1:0]                 ur_rvalid,
    input  logic                              i_fill_start,
    input  logic [DATA_WIDTH-1:0]             i_src_random_data,
    output logic                              o_fill_busy,
    input  logic                              i_err_clr,
    output logic                              o_err,
    output logic [31:0]                       o_rd_cnt,
    output logic [31:0]                       o_wr_cnt
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [UR_ADDR_WIDTH:0] DEPTH_L  = (UR_ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IW-1:0]          LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] byte_merge(input logic [DATA_WIDTH-1:0] old_v,
                                                         input logic [DATA_WIDTH-1:0] new_v,
                                                         input logic [NB-1:0]         strb);
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < NB; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic in_range(input logic [UR_ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < DEPTH_L);
    endfunction

    function automatic logic [IW-1:0] to_idx(input logic [UR_ADDR_WIDTH-1:0] addr);
        return addr[IW-1:0];
    endfunction

    function automatic logic [31:0] popcount(input logic [NUM_RD-1:0] v);
        logic [31:0] cnt;
        cnt = 32'd0;
        for (int k = 0; k < NUM_RD; k++) begin
            cnt = cnt + 32'(v[k]);
        end
        return cnt;
    endfunction

    state_t                    state_r;
    logic [IW-1:0]             idx_r;
    logic                      fill_busy_r;
    logic [DATA_WIDTH-1:0]     mem_r [DEPTH];
    logic [DATA_WIDTH-1:0]     rdata_r [NUM_RD];
    logic [NUM_RD-1:0]         rvalid_r;
    logic                      err_r;
    logic [31:0]               rd_cnt_r;
    logic [31:0]               wr_cnt_r;

    logic                      idle_s;
    logic                      wr_ok_s;
    logic [DATA_WIDTH-1:0]     wr_merged_s;
    logic [UR_ADDR_WIDTH-1:0]  raddr_s [NUM_RD];
    logic [DATA_WIDTH-1:0]     rd_data_s [NUM_RD];
    logic [NUM_RD-1:0]         rd_acc_s;
    logic                      err_set_s;

    assign idle_s      = (state_r == ST_IDLE);
    assign wr_ok_s     = idle_s & ur_we & in_range(ur_waddr);
    assign wr_merged_s = byte_merge(mem_r[to_idx(ur_waddr)], ur_wdata, ur_wstrb);

    // Per-port read data: write-first bypass, zero for out-of-range addresses
    always_comb begin
        err_set_s = idle_s & ur_we & ~in_range(ur_waddr);
        for (int k = 0; k < NUM_RD; k++) begin
            raddr_s[k]   = ur_raddr[k*UR_ADDR_WIDTH +: UR_ADDR_WIDTH];
            rd_acc_s[k]  = idle_s & ur_re[k];
            rd_data_s[k] = '0;
            if (!in_range(raddr_s[k])) begin
                rd_data_s[k] = '0;
            end else if (wr_ok_s && (ur_waddr == raddr_s[k])) begin
                rd_data_s[k] = wr_merged_s;
            end else begin
                rd_data_s[k] = mem_r[to_idx(raddr_s[k])];
            end
            err_set_s = err_set_s | (rd_acc_s[k] & ~in_range(raddr_s[k]));
        end
    end

    // Fill sequencer: walks idx over every entry once, then returns to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            fill_busy_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_fill_start) begin
                        state_r     <= ST_FILL;
                        idx_r       <= '0;
                        fill_busy_r <= 1'b1;
                    end else begin
                        state_r     <= ST_IDLE;
                        fill_busy_r <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (idx_r == LAST_IDX) begin
                        state_r     <= ST_IDLE;
                        idx_r       <= '0;
                        fill_busy_r <= 1'b0;
                    end else begin
                        idx_r       <= idx_r + IW'(1);
                        fill_busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    idx_r       <= '0;
                    fill_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: fill has priority; host writes only land while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (state_r == ST_FILL) begin
            mem_r[idx_r] <= i_src_random_data;
        end else if (wr_ok_s) begin
            mem_r[to_idx(ur_waddr)] <= wr_merged_s;
        end
    end

    // Read hold registers and registered valid pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_RD; k++) begin
                rdata_r[k] <= '0;
            end
            rvalid_r <= '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                if (rd_acc_s[k]) begin
                    rdata_r[k] <= rd_data_s[k];
                end
            end
            rvalid_r <= rd_acc_s;
        end
    end

    // Sticky error flag (set beats clear) and wrapping access counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r    <= 1'b0;
            rd_cnt_r <= 32'd0;
            wr_cnt_r <= 32'd0;
        end else begin
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (i_err_clr) begin
                err_r <= 1'b0;
            end
            rd_cnt_r <= rd_cnt_r + popcount(rd_acc_s);
            wr_cnt_r <= wr_cnt_r + 32'(wr_ok_s);
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_out
            if (RD_LAT == 0) begin : g_lat0
                assign ur_rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd_acc_s[k] ? rd_data_s[k] : rdata_r[k];
                assign ur_rvalid[k] = rd_acc_s[k];
            end else begin : g_lat1
                assign ur_rdata[k*DATA_WIDTH +: DATA_WIDTH] = rdata_r[k];
                assign ur_rvalid[k] = rvalid_r[k];
            end
        end
    endgenerate

    assign o_fill_busy = fill_busy_r;
    assign o_err       = err_r;
    assign o_rd_cnt    = rd_cnt_r;
    assign o_wr_cnt    = wr_cnt_r;

endmodule

// File: tb/tb_user_reg_file.sv
// Bench for user_reg_file (default parameters, RD_LAT=1): directed vector table,
// fill sequences, randomized traffic against a behavioural register-file model.
module tb_user_reg_file;

    logic           clk;
    logic           rst_n;
    logic           ur_we;
    logic [10:0]    ur_waddr;
    logic [127:0]   ur_wdata;
    logic [15:0]    ur_wstrb;
    logic [1:0]     ur_re;
    logic [21:0]    ur_raddr;
    logic [255:0]   ur_rdata;
    logic [1:0]     ur_rvalid;
    logic           i_fill_start;
    logic [127:0]   i_src_random_data;
    logic           o_fill_busy;
    logic           i_err_clr;
    logic           o_err;
    logic [31:0]    o_rd_cnt;
    logic [31:0]    o_wr_cnt;

    int checks = 0;
    int errors = 0;

    user_reg_file dut (
        .clk(clk), .rst_n(rst_n),
        .ur_we(ur_we), .ur_waddr(ur_waddr), .ur_wdata(ur_wdata), .ur_wstrb(ur_wstrb),
        .ur_re(ur_re), .ur_raddr(ur_raddr), .ur_rdata(ur_rdata), .ur_rvalid(ur_rvalid),
        .i_fill_start(i_fill_start), .i_src_random_data(i_src_random_data),
        .o_fill_busy(o_fill_busy), .i_err_clr(i_err_clr), .o_err(o_err),
        .o_rd_cnt(o_rd_cnt), .o_wr_cnt(o_wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain array of 64 entries plus observable state
    logic [127:0] mem_m [64];
    logic [127:0] hold_m [2];
    logic [1:0]   rv_m;
    logic         err_m;
    logic [31:0]  rc_m, wc_m;

    typedef struct {
        logic         we;
        logic [10:0]  wa;
        logic [127:0] wd;
        logic [15:0]  ws;
        logic [1:0]   re;
        logic [10:0]  ra0, ra1;
        logic         clr;
        logic [127:0] e0, e1;
        logic [1:0]   erv;
        logic         eerr;
        logic [31:0]  erc, ewc;
    } vec_t;
    vec_t vecs[$];

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mem_m[i] = '0;
        hold_m[0] = '0; hold_m[1] = '0;
        rv_m = 2'b00; err_m = 1'b0; rc_m = 32'd0; wc_m = 32'd0;
    endtask

    // Write-first: the write lands first, reads then observe the updated array
    task automatic model_step(input logic we, input logic [10:0] wa, input logic [127:0] wd,
                              input logic [15:0] ws, input logic [1:0] re,
                              input logic [10:0] ra0, input logic [10:0] ra1, input logic clr);
        logic set;
        int   ra;
        set = 1'b0;
        if (we) begin
            if (wa < 11'd64) begin
                for (int b = 0; b < 16; b++)
                    if (ws[b]) mem_m[wa][b*8 +: 8] = wd[b*8 +: 8];
                wc_m = wc_m + 32'd1;
            end else begin
                set = 1'b1;
            end
        end
        rv_m = 2'b00;
        for (int k = 0; k < 2; k++) begin
            ra = (k == 0) ? int'(ra0) : int'(ra1);
            if (re[k]) begin
                rv_m[k] = 1'b1;
                rc_m = rc_m + 32'd1;
                if (ra < 64) begin
                    hold_m[k] = mem_m[ra];
                end else begin
                    hold_m[k] = '0;
                    set = 1'b1;
                end
            end
        end
        err_m = set | (err_m & ~clr);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [127:0] e0, input logic [127:0] e1,
                           input logic [1:0] erv, input logic eerr,
                           input logic [31:0] erc, input logic [31:0] ewc);
        chk({tag, " rdata0"}, ur_rdata[127:0], e0);
        chk({tag, " rdata1"}, ur_rdata[255:128], e1);
        chk({tag, " rvalid"}, 128'(ur_rvalid), 128'(erv));
        chk({tag, " err"}, 128'(o_err), 128'(eerr));
        chk({tag, " rd_cnt"}, 128'(o_rd_cnt), 128'(erc));
        chk({tag, " wr_cnt"}, 128'(o_wr_cnt), 128'(ewc));
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, hold_m[0], hold_m[1], rv_m, err_m, rc_m, wc_m);
    endtask

    task automatic step(input logic we, input logic [10:0] wa, input logic [127:0] wd,
                        input logic [15:0] ws, input logic [1:0] re,
                        input logic [10:0] ra0, input logic [10:0] ra1, input logic clr);
        ur_we = we; ur_waddr = wa; ur_wdata = wd; ur_wstrb = ws;
        ur_re = re; ur_raddr = {ra1, ra0}; i_err_clr = clr;
        @(posedge clk);
        model_step(we, wa, wd, ws, re, ra0, ra1, clr);
        #1;
    endtask

    task automatic add(input logic we, input logic [10:0] wa, input logic [127:0] wd,
                       input logic [15:0] ws, input logic [1:0] re, input logic [10:0] ra0,
                       input logic [10:0] ra1, input logic clr, input logic [127:0] e0,
                       input logic [127:0] e1, input logic [1:0] erv, input logic eerr,
                       input logic [31:0] erc, input logic [31:0] ewc);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ws = ws; v.re = re; v.ra0 = ra0; v.ra1 = ra1;
        v.clr = clr; v.e0 = e0; v.e1 = e1; v.erv = erv; v.eerr = eerr; v.erc = erc; v.ewc = ewc;
        vecs.push_back(v);
    endtask

    // Runs a fill with src = busy-cycle index; abort_at >= 0 pulls reset at that index
    task automatic do_fill(input int abort_at, output int busy_cycles);
        int cnt;
        ur_we = 1'b0; ur_re = 2'b00; i_err_clr = 1'b0;
        i_fill_start = 1'b1;
        @(posedge clk); #1;
        i_fill_start = 1'b0;
        cnt = 0;
        while (o_fill_busy && cnt < 200) begin
            if (cnt == abort_at) begin
                rst_n = 1'b0;
                #1;
                busy_cycles = cnt;
                return;
            end
            i_src_random_data = 128'(cnt);
            i_fill_start = (cnt == 5);
            ur_re    = (cnt == 10) ? 2'b01 : 2'b00;
            ur_raddr = 22'd0;
            ur_we    = (cnt == 20);
            ur_waddr = (cnt == 20) ? 11'd0 : 11'd100;
            ur_wdata = {128{1'b1}};
            ur_wstrb = 16'hFFFF;
            @(posedge clk); #1;
            if (cnt == 10) chk("fill read rvalid", 128'(ur_rvalid), 128'd0);
            cnt++;
        end
        i_fill_start = 1'b0; ur_we = 1'b0; ur_re = 2'b00;
        busy_cycles = cnt;
    endtask

    localparam logic [127:0] P11 = {16{8'h11}};
    localparam logic [127:0] P22 = {16{8'h22}};
    localparam logic [127:0] MIX = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [127:0] WD3 = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_AABB;

    initial begin
        int bc;
        logic        rwe, rclr;
        logic [10:0] rwa, rra0, rra1;
        logic [1:0]  rre;

        rst_n = 1'b0; ur_we = 1'b0; ur_waddr = '0; ur_wdata = '0; ur_wstrb = '0;
        ur_re = '0; ur_raddr = '0; i_fill_start = 1'b0; i_src_random_data = '0; i_err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 128'd0, 128'd0, 2'b00, 1'b0, 32'd0, 32'd0);
        chk("reset busy", 128'(o_fill_busy), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //   we  wa      wd    ws        re     ra0     ra1    clr   e0          e1    erv    err   rc  wc
        add(1'b0, 11'd0,   '0,  16'h0000, 2'b01, 11'd5,  11'd0, 1'b0, 128'd0,     '0,   2'b01, 1'b0, 1, 0);
        add(1'b0, 11'd0,   '0,  16'h0000, 2'b00, 11'd0,  11'd0, 1'b0, 128'd0,     '0,   2'b00, 1'b0, 1, 0);
        add(1'b1, 11'd3,   WD3, 16'h0003, 2'b00, 11'd0,  11'd0, 1'b0, 128'd0,     '0,   2'b00, 1'b0, 1, 1);
        add(1'b0, 11'd0,   '0,  16'h0000, 2'b01, 11'd3,  11'd0, 1'b0, 128'hAABB,  '0,   2'b01, 1'b0, 2, 1);
        add(1'b1, 11'd7,   P22, 16'hFFFF, 2'b00, 11'd0,  11'd0, 1'b0, 128'hAABB,  '0,   2'b00, 1'b0, 2, 2);
        add(1'b1, 11'd7,   P11, 16'h00FF, 2'b11, 11'd7,  11'd7, 1'b0, MIX,        MIX,  2'b11, 1'b0, 4, 3);
        add(1'b0, 11'd0,   '0,  16'h0000, 2'b00, 11'd0,  11'd0, 1'b0, MIX,        MIX,  2'b00, 1'b0, 4, 3);
        add(1'b1, 11'd100, P11, 16'hFFFF, 2'b01, 11'd64, 11'd0, 1'b0, 128'd0,     MIX,  2'b01, 1'b1, 5, 3);
        add(1'b0, 11'd0,   '0,  16'h0000, 2'b01, 11'd70, 11'd0, 1'b1, 128'd0,     MIX,  2'b01, 1'b1, 6, 3);
        add(1'b0, 11'd0,   '0,  16'h0000, 2'b00, 11'd0,  11'd0, 1'b1, 128'd0,     MIX,  2'b00, 1'b0, 6, 3);
        add(1'b0, 11'd0,   '0,  16'h0000, 2'b11, 11'd36, 11'd7, 1'b0, 128'd0,     MIX,  2'b11, 1'b0, 8, 3);

        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ws, vecs[i].re,
                 vecs[i].ra0, vecs[i].ra1, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].erv,
                    vecs[i].eerr, vecs[i].erc, vecs[i].ewc);
        end

        // Full fill: entry i gets i; reads/writes/restart during the fill are dropped
        do_fill(-1, bc);
        chk("fill busy cycles", 128'(bc), 128'd64);
        for (int i = 0; i < 64; i++) mem_m[i] = 128'(i);
        rv_m = 2'b00;
        chk_model("post fill");
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 11'd0, '0, 16'h0000, 2'b11, 11'(i), 11'(63 - i), 1'b0);
            chk_model($sformatf("fill readback %0d", i));
        end

        // Randomized traffic, with some out-of-range and colliding addresses
        for (int n = 0; n < 400; n++) begin
            rwe  = ($urandom_range(0, 2) != 0);
            rwa  = 11'($urandom_range(0, 79));
            rre  = 2'($urandom_range(0, 3));
            rra0 = ($urandom_range(0, 3) == 0) ? rwa : 11'($urandom_range(0, 79));
            rra1 = ($urandom_range(0, 3) == 0) ? rwa : 11'($urandom_range(0, 79));
            rclr = ($urandom_range(0, 7) == 0);
            step(rwe, rwa, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
                 rre, rra0, rra1, rclr);
            chk_model($sformatf("rand %0d", n));
        end

        // Reset in the middle of a fill
        do_fill(20, bc);
        chk("abort idx", 128'(bc), 128'd20);
        chk("abort busy", 128'(o_fill_busy), 128'd0);
        model_reset();
        chk_model("abort reset");
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b0, 11'd0, '0, 16'h0000, 2'b11, 11'd10, 11'd19, 1'b0);
        chk_model("post abort read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
